// File: rtl/decode_queue.sv
// Instruction decode byte queue: consume from the head and refill from the fetch word in the same cycle.
// Define DECODE_LEN_LIMIT_EN to compile in the instruction-length cap and the sticky dec_len_fault flag.
module decode_queue #(
   parameter int BUF_BYTES   = 12,
   parameter int FETCH_BYTES = 8,
   parameter int MAX_INSN    = 15,
   parameter int CW          = $clog2(BUF_BYTES + 1),
   parameter int FW          = $clog2(FETCH_BYTES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_reset,
   input  logic [FW-1:0]            fetch_valid,
   input  logic [8*FETCH_BYTES-1:0] fetch,
   input  logic [3:0]               prefix_count,
   input  logic [CW-1:0]            consume_count,
   output logic [FW-1:0]            dec_acceptable,
   output logic [8*BUF_BYTES-1:0]   decoder,
   output logic [CW-1:0]            decoder_count,
   output logic                     dec_empty,
   output logic                     dec_full,
   output logic                     dec_len_fault
);

   logic [8*BUF_BYTES-1:0] decoder_q, decoder_d, shifted;
   logic [CW-1:0]          count_q, count_d;
   logic                   fault_w;
   int                     cnt, eff, aft, acc, accd, fv;

`ifdef DECODE_LEN_LIMIT_EN
   logic fault_q;
   logic fault_set;
   int   used;

   assign fault_w = fault_q;
`else
   logic unused_prefix;

   assign fault_w       = 1'b0;
   assign unused_prefix = ^prefix_count;
`endif

   always_comb begin
      cnt = int'(count_q);
      fv  = int'(fetch_valid);
      eff = (int'(consume_count) > cnt) ? cnt : int'(consume_count);
      aft = cnt - eff;
      acc = BUF_BYTES - aft;
      if (acc > FETCH_BYTES) acc = FETCH_BYTES;
`ifdef DECODE_LEN_LIMIT_EN
      used = int'(prefix_count) + aft;
      if (used >= MAX_INSN) acc = 0;
      else if (acc > MAX_INSN - used) acc = MAX_INSN - used;
`endif
      if (rst || dec_reset || fault_w) acc = 0;
      accd = (fv < acc) ? fv : acc;

      // Bytes past the surviving count are rebuilt from fetch or zeroed, so stale data never lingers.
      shifted   = decoder_q >> (8 * eff);
      decoder_d = '0;
      for (int i = 0; i < BUF_BYTES; i++) begin
         if (i < aft)
            decoder_d[8*i +: 8] = shifted[8*i +: 8];
         else if (i < aft + accd)
            decoder_d[8*i +: 8] = fetch[8*(i-aft) +: 8];
      end
      count_d = CW'(aft + accd);
   end

   assign dec_acceptable = FW'(acc);

   always_ff @(posedge clk) begin
      if (rst || dec_reset) begin
         decoder_q <= '0;
         count_q   <= '0;
      end else begin
         decoder_q <= decoder_d;
         count_q   <= count_d;
      end
   end

`ifdef DECODE_LEN_LIMIT_EN
   // Fault looks at the registered count, so it flags an instruction that has already outgrown the limit.
   assign fault_set = ((int'(prefix_count) + int'(count_q)) >= MAX_INSN) && (consume_count == '0);

   always_ff @(posedge clk) begin
      if (rst || dec_reset) fault_q <= 1'b0;
      else if (fault_set)   fault_q <= 1'b1;
   end
`endif

   assign decoder       = decoder_q;
   assign decoder_count = count_q;
   assign dec_empty     = (count_q == '0);
   assign dec_full      = (count_q == CW'(BUF_BYTES));
   assign dec_len_fault = fault_w;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue at default parameters; a byte-queue model predicts every update.
module tb_decode_queue;
   localparam int BB = 12;
   localparam int FB = 8;
   localparam int MI = 15;
   localparam int CW = 4;
   localparam int FW = 4;

   logic            clk = 1'b0;
   logic            rst, dec_reset;
   logic [FW-1:0]   fetch_valid;
   logic [8*FB-1:0] fetch;
   logic [3:0]      prefix_count;
   logic [CW-1:0]   consume_count;
   logic [FW-1:0]   dec_acceptable;
   logic [8*BB-1:0] decoder;
   logic [CW-1:0]   decoder_count;
   logic            dec_empty, dec_full, dec_len_fault;

   decode_queue dut (
      .clk(clk), .rst(rst), .dec_reset(dec_reset), .fetch_valid(fetch_valid),
      .fetch(fetch), .prefix_count(prefix_count), .consume_count(consume_count),
      .dec_acceptable(dec_acceptable), .decoder(decoder), .decoder_count(decoder_count),
      .dec_empty(dec_empty), .dec_full(dec_full), .dec_len_fault(dec_len_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              cnt;
      logic [8*BB-1:0] dat;
      logic            flt;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mq[$];
   logic       mfault = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic dr, input int pc, input int cc,
                       input int fv, input logic [8*FB-1:0] fb);
      int   cnt, eff, aft, acc, accd;
      exp_t e;
      rst = r; dec_reset = dr; prefix_count = 4'(pc);
      consume_count = CW'(cc); fetch_valid = FW'(fv); fetch = fb;
      #1;
      cnt = mq.size();
      eff = (cc < cnt) ? cc : cnt;
      aft = cnt - eff;
      acc = BB - aft;
      if (acc > FB) acc = FB;
`ifdef DECODE_LEN_LIMIT_EN
      if (pc + aft >= MI) acc = 0;
      else if (acc > MI - (pc + aft)) acc = MI - (pc + aft);
`endif
      if (r || dr || mfault) acc = 0;
      chk("acceptable", dec_acceptable, acc);
      accd = (fv < acc) ? fv : acc;
      if (r || dr) begin
         mq.delete();
         mfault = 1'b0;
      end else begin
`ifdef DECODE_LEN_LIMIT_EN
         if (pc + cnt >= MI && cc == 0) mfault = 1'b1;
`endif
         for (int k = 0; k < eff; k++) void'(mq.pop_front());
         for (int k = 0; k < accd; k++) mq.push_back(fb[8*k +: 8]);
      end
      e.cnt = mq.size();
      e.dat = '0;
      foreach (mq[k]) e.dat[8*k +: 8] = mq[k];
      e.flt = mfault;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("count", decoder_count, e.cnt);
      chk("decoder", decoder, e.dat);
      chk("empty", dec_empty, e.cnt == 0);
      chk("full", dec_full, e.cnt == BB);
      chk("len_fault", dec_len_fault, e.flt);
   endtask

   initial begin
      logic [8*BB-1:0] held;
      rst = 1'b1; dec_reset = 1'b0; prefix_count = '0; consume_count = '0;
      fetch_valid = '0; fetch = '0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 0, 0, 8, 64'hFFEE_DDCC_BBAA_9988);
      chk("rst_acceptable", dec_acceptable, 0);

      // fill 8 bytes from empty
      step(1'b0, 1'b0, 0, 0, 8, 64'h0807_0605_0403_0201);
      chk("fill8_low", decoder[63:0], 64'h0807_0605_0403_0201);
      chk("fill8_cnt", decoder_count, 8);

      // consume 3 and refill 7 in the same cycle
      step(1'b0, 1'b0, 0, 3, 8, 64'h1817_1615_1413_1211);
      chk("refill_cnt", decoder_count, 12);
      chk("refill_full", dec_full, 1);
      chk("refill_head", decoder[7:0], 8'h04);
      chk("refill_new", decoder[95:40], 56'h17_1615_1413_1211);

      held = decoder;
      for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 0, 0, 8, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("full_hold", decoder, held);

      // over-consume is clamped, no wrap
      step(1'b0, 1'b0, 0, 8, 0, 64'h0);
      step(1'b0, 1'b0, 0, 9, 3, 64'h0000_0000_0033_2211);
      chk("clamp_cnt", decoder_count, 3);

      step(1'b0, 1'b0, 0, 0, 6, 64'h0000_6655_4433_2211);
      step(1'b0, 1'b1, 0, 2, 8, 64'h7777_7777_7777_7777);
      chk("flush_cnt", decoder_count, 0);
      chk("flush_data", decoder, 96'h0);

`ifdef DECODE_LEN_LIMIT_EN
      step(1'b0, 1'b0, 0, 0, 8, 64'h0807_0605_0403_0201);
      step(1'b0, 1'b0, 0, 0, 3, 64'h0000_0000_000B_0A09);
      chk("lim_cnt11", decoder_count, 11);
      step(1'b0, 1'b0, 4, 0, 8, 64'h1111_1111_1111_1111);
      chk("lim_fault", dec_len_fault, 1);
      step(1'b0, 1'b0, 0, 2, 8, 64'h2222_2222_2222_2222);
      step(1'b0, 1'b1, 0, 0, 8, 64'h0);
      chk("lim_cleared", dec_len_fault, 0);
`endif

      for (int n = 0; n < 300; n++) begin
         step(1'b0, ($urandom_range(0, 29) == 0), $urandom_range(0, 4),
              $urandom_range(0, 15), $urandom_range(0, 8), {$urandom, $urandom});
      end

      // reset mid-stream drops everything, then resume
      step(1'b0, 1'b0, 0, 0, 8, 64'h8877_6655_4433_2211);
      step(1'b1, 1'b0, 0, 1, 8, 64'h9999_9999_9999_9999);
      chk("midrst_empty", dec_empty, 1);
      step(1'b0, 1'b0, 0, 0, 5, 64'h0000_00EE_DDCC_BBAA);
      chk("resume_data", decoder[39:0], 40'hEE_DDCC_BBAA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
